// File: rtl/rotate_arbiter.sv
// Round-robin arbiter in front of one shared 2^N-bit barrel rotator.
// The granted request is rotated and captured in a one-entry result register.

module rot_stage #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             left,
  output logic [WIDTH-1:0] q
);
  always_comb begin
    q = d;
    if (en) begin
      if (left) q = {d[WIDTH-SHIFT-1:0], d[WIDTH-1:WIDTH-SHIFT]};
      else      q = {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
    end
  end
endmodule

module rotate_arbiter #(
  parameter  int N     = 4,
  parameter  int NREQ  = 4,
  localparam int WIDTH = 2**N,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*N-1:0]     req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic [15:0]           op_count
);
  logic [IDW-1:0] ptr, winner, cand;
  logic           found, can_accept, accept;
  logic [WIDTH-1:0] g_data;
  logic [N-1:0]     g_amt;
  logic             g_dir;
  logic [N:0][WIDTH-1:0] stg;

  // Search starts at ptr and wraps, so the first valid hit is the round-robin winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign accept     = can_accept && found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  assign g_data = req_data[int'(winner)*WIDTH +: WIDTH];
  assign g_amt  = req_amt[int'(winner)*N +: N];
  assign g_dir  = req_dir[winner];
  assign stg[0] = g_data;

  // Stage s rotates by 2^s when amount bit s is set; right rotates compose like left ones.
  for (genvar s = 0; s < N; s++) begin : g_rot
    rot_stage #(.WIDTH(WIDTH), .SHIFT(2**s)) u_stage (
      .d    (stg[s]),
      .en   (g_amt[s]),
      .left (g_dir),
      .q    (stg[s+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      op_count  <= '0;
    end else if (accept) begin
      ptr       <= IDW'((int'(winner) + 1) % NREQ);
      out_valid <= 1'b1;
      out_data  <= stg[N];
      out_id    <= winner;
      op_count  <= op_count + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/rotate_arbiter.md
# rotate_arbiter

Round-robin arbiter and sequencer that shares one combinational barrel rotator (2^N-bit, left/right rotate) among NREQ requesters. Each requester presents a rotate request over a valid/ready handshake. The granted request is rotated and captured in a one-entry output register, tagged with the requester index. It sits between the requesting datapath clients and downstream consumers, so they never instantiate private rotators.

## Interface
- N, 4, log2 of data width; WIDTH = 2**N
- NREQ, 4, number of requesters (2..16); IDW = $clog2(NREQ)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (combinational)
- req_data  input  NREQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
- req_amt  input  NREQ*N  packed rotate amounts; requester i at [i*N +: N]
- req_dir  input  NREQ  per-requester direction; 1 = rotate left, 0 = rotate right
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  rotated result
- out_id  output  IDW  index of the requester that produced out_data
- op_count  output  16  number of accepted requests, wraps at 2^16

## Operation
- Rotation, with k = amt (0..WIDTH-1):
  - Left: result[(j+k) mod WIDTH] = data[j].
  - Right: result[j] = data[(j+k) mod WIDTH].
  - k = 0 passes data through unchanged in both directions.
- One rotator instance is shared. Its inputs are muxed from the granted requester.
- Round-robin pointer ptr (IDW bits, reset 0):
  - Winner = first i with req_valid[i] set, searching ptr, ptr+1, … with wrap mod NREQ.
  - On accept from requester g, ptr <= (g+1) mod NREQ.
  - With no accept, ptr holds.
- can_accept = !out_valid || out_ready.
- req_ready[i] = can_accept && (i == winner) && req_valid[i] && !rst. At most one bit is set.
- Accept: req_valid[g] && req_ready[g]. On accept:
  - out_data <= rotate(req_data[g], req_amt[g], req_dir[g])
  - out_id <= g
  - out_valid <= 1
  - op_count <= op_count + 1
- Drain without accept (out_valid && out_ready, no accept): out_valid <= 0. out_data and out_id hold their last values.
- Backpressure (out_valid && !out_ready): all req_ready = 0. out_data, out_id and ptr are held stable.
- Simultaneous drain and accept in one cycle: the new result replaces the old one. out_valid stays 1, giving one result per cycle throughput.
- A requester may drop req_valid before it is accepted. It is then simply skipped; no grant is stored.
- Reset values: out_valid 0, out_data 0, out_id 0, ptr 0, op_count 0. req_ready is forced to 0 while rst = 1.
- Reset mid-operation discards the held result. No request is accepted in the reset cycle.

## Timing
- Latency is 1 cycle: a request accepted at edge t appears on out_data/out_id with out_valid = 1 after edge t.
- Throughput is 1 result per cycle while out_ready = 1 and any req_valid is set.
- req_ready depends combinationally on req_valid, ptr, out_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- The comb path is the round-robin priority search, then the NREQ:1 mux, then the N-stage rotator, then the output register.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- op_count increments exactly once per accept. It wraps 0xFFFF -> 0x0000.

## Test plan
- Right rotate: N=4, requester 1 only, data 0x8001, amt 1, dir 0, out_ready 1 -> next cycle out_valid 1, out_data 0xC000, out_id 1, op_count 1.
- Left rotate and boundaries: data 0x8001, dir 1, amt 4 -> 0x0018. Then amt 0 -> 0x8001. Then amt 15, dir 1 -> 0xC000.
- Round-robin: all 4 requesters valid continuously with distinct data, out_ready 1 -> out_id sequence 0,1,2,3,0 on consecutive cycles. Then only requesters 0 and 2 valid, starting from ptr=1 -> sequence 2,0,2,0.
- Backpressure: result held, out_ready 0 for 3 cycles with requesters valid -> req_ready = 0; out_data, out_id and op_count are stable. Raise out_ready -> the held result drains and the next request is accepted in the same cycle, so out_valid stays 1.
- Reset mid-stream: rst asserted for 1 cycle while out_valid = 1 and requests are pending -> after the edge out_valid 0, out_data 0, op_count 0, ptr 0. The first accept after reset goes to the lowest-index valid requester.
- Counter wrap: 65536 accepts -> op_count returns to 0x0000. Scoreboard compares every out_data against the rotation definition above, for random data, amt and dir.
